// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide unit.
interface muldiv_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             flush;
   logic [2:0]       func3;
   logic [WIDTH-1:0] srcA;
   logic [WIDTH-1:0] srcB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (output start, flush, func3, srcA, srcB,
                   input  busy, done, result);
   modport slave  (input  start, flush, func3, srcA, srcB,
                   output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with sign fix-up on the way out and single-cycle divide corner cases.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_unit_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] opd_q, opd_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             a_sgn, b_sgn, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             div_zero, div_ovf;
   logic [WIDTH:0]   mul_sum, div_hi, div_diff;
   logic [PW-1:0]    it_acc, prod_s;
   logic [WIDTH-1:0] quo_sel, fin_v;

   // Request decode: operand signedness, magnitudes and the single-cycle divide cases
   always_comb begin
      a_sgn    = (bus.func3 == 3'b001) || (bus.func3 == 3'b010) || (bus.func3[2] && !bus.func3[0]);
      b_sgn    = (bus.func3 == 3'b001) || (bus.func3[2] && !bus.func3[0]);
      a_neg    = a_sgn && bus.srcA[WIDTH-1];
      b_neg    = b_sgn && bus.srcB[WIDTH-1];
      a_mag    = a_neg ? (~bus.srcA + WIDTH'(1)) : bus.srcA;
      b_mag    = b_neg ? (~bus.srcB + WIDTH'(1)) : bus.srcB;
      div_zero = bus.func3[2] && (bus.srcB == '0);
      div_ovf  = bus.func3[2] && !bus.func3[0] &&
                 (bus.srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.srcB == '1);
   end

   // One iteration step plus the signed result that the last step would produce
   always_comb begin
      mul_sum  = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
      div_hi   = acc_q[PW-1:WIDTH-1];
      div_diff = div_hi - {1'b0, opd_q};
      if (op_q[2]) begin
         if (!div_diff[WIDTH]) it_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else                  it_acc = {div_hi[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         it_acc = {mul_sum, acc_q[WIDTH-1:1]};
      end
      prod_s  = neg_q ? (~it_acc + PW'(1)) : it_acc;
      quo_sel = op_q[1] ? it_acc[PW-1:WIDTH] : it_acc[WIDTH-1:0];
      if (op_q[2])                  fin_v = neg_q ? (~quo_sel + WIDTH'(1)) : quo_sel;
      else if (op_q[1:0] == 2'b00)  fin_v = prod_s[WIDTH-1:0];
      else                          fin_v = prod_s[PW-1:WIDTH];
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opd_d    = opd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      if (bus.flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_RUN: begin
               acc_d = it_acc;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_d  = ST_DONE;
                  result_d = fin_v;
               end
            end
            default: begin
               if (bus.start) begin
                  op_d  = bus.func3;
                  cnt_d = CW'(WIDTH - 1);
                  neg_d = (bus.func3[2] && bus.func3[1]) ? a_neg : (a_neg ^ b_neg);
                  if (div_zero) begin
                     state_d  = ST_DONE;
                     result_d = bus.func3[1] ? bus.srcA : '1;
                  end else if (div_ovf) begin
                     state_d  = ST_DONE;
                     result_d = bus.func3[1] ? '0 : bus.srcA;
                  end else begin
                     state_d = ST_RUN;
                     opd_d   = bus.func3[2] ? b_mag : a_mag;
                     acc_d   = {{WIDTH{1'b0}}, (bus.func3[2] ? a_mag : b_mag)};
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         opd_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opd_q    <= opd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = (state_q == ST_RUN);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, flush/reset aborts,
// back-to-back requests and randomized ops against a plain-arithmetic reference.
`timescale 1ns/1ps
module tb_muldiv_unit;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(W)) bus ();
   muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          n_total = 0;
   int          n_bad   = 0;
   logic [31:0] last_res = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: RV32M semantics with 64-bit integer arithmetic
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      logic [31:0] r;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'h0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Called at the negedge of cycle N+1; returns at the negedge of the done cycle
   task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
      int lat, busy_err;
      lat = 1;
      busy_err = 0;
      while (bus.done !== 1'b1 && lat < 100) begin
         if (bus.busy !== 1'b1) busy_err++;
         @(negedge clk);
         lat++;
      end
      if (bus.busy !== 1'b0) busy_err++;
      check({tag, "_busy"}, 64'(busy_err), 64'd0);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_res"}, {32'h0, bus.result}, {32'h0, exp_res});
      last_res = exp_res;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res);
      @(negedge clk);
      bus.start = 1'b1; bus.func3 = f; bus.srcA = a; bus.srcB = b;
      @(negedge clk);
      bus.start = 1'b0; bus.func3 = 3'($urandom); bus.srcA = $urandom; bus.srcB = $urandom;
      wait_done(tag, is_fast(f, a, b) ? 1 : 33, exp_res);
      @(negedge clk);
      check({tag, "_hold"}, {31'h0, bus.done, bus.result}, {31'h0, 1'b0, last_res});
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.flush = 1'b0; bus.func3 = '0; bus.srcA = '0; bus.srcB = '0;
      #12;
      check("reset_out", {31'h0, bus.busy, bus.done, bus.result}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
      run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
      run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
      run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14);
      run_op("divu0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF);
      run_op("remu0",  3'd7, 32'd5,          32'd0,         32'd5);
      run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
      run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0);

      // Flush partway through a divide
      run_op("pre", 3'd0, 32'd5, 32'd5, 32'd25);
      @(negedge clk);
      bus.start = 1'b1; bus.func3 = 3'd4; bus.srcA = 32'd1000; bus.srcB = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      check("flush_busy_n10", {63'h0, bus.busy}, 64'h1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_idle", {31'h0, bus.busy, bus.done, bus.result}, {32'h0, 32'd25});
      expect_quiet("flush_nodone", 40);
      run_op("flush_mul", 3'd0, 32'd3, 32'd4, 32'd12);

      // Flush and start together: request dropped
      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.func3 = 3'd0; bus.srcA = 32'd9; bus.srcB = 32'd9;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      check("flush_start", {31'h0, bus.busy, bus.done, bus.result}, {32'h0, 32'd12});
      expect_quiet("flush_start_quiet", 5);

      // Asynchronous reset mid-RUN
      @(negedge clk);
      bus.start = 1'b1; bus.func3 = 3'd3; bus.srcA = 32'hDEAD_BEEF; bus.srcB = 32'h1234_5678;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid", {31'h0, bus.busy, bus.done, bus.result}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_quiet("rst_nodone", 40);
      last_res = '0;
      run_op("rst_after", 3'd5, 32'd81, 32'd9, 32'd9);

      // Start held high: operand changes during RUN ignored, second op accepted in DONE
      @(negedge clk);
      bus.start = 1'b1; bus.func3 = 3'd0; bus.srcA = 32'd2; bus.srcB = 32'd3;
      @(negedge clk);
      bus.func3 = 3'd5; bus.srcA = 32'd9; bus.srcB = 32'd3;
      wait_done("b2b_mul", 33, 32'd6);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("b2b_divu", 33, 32'd3);
      @(negedge clk);
      check("b2b_end", {31'h0, bus.done, bus.result}, {32'h0, 32'd3});

      // Randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom);
         a = pick();
         b = pick();
         run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, ref_op(f, a, b));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
